// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline (execute -> writeback).
// Loads and stores run one request/ready transaction against data memory.
// Misaligned or unsupported-size accesses and memory timeouts retire as
// flagged, non-writing writeback entries.
//
// Memory handshake: mem_req_o rises on the edge that accepts an aligned
// memory op and stays high, with we/addr/be/wdata frozen, until the first
// cycle in which mem_ready_i is sampled high (transfer completes at that edge)
// or the wait budget runs out (abort at that edge). mem_rdata_i is only used
// in a cycle where mem_req_o & mem_ready_i; mem_ready_i is ignored otherwise.
module mem_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ValidE_i,
  input  logic                     MemReadE_i,
  input  logic                     MemWriteE_i,
  input  logic [2:0]               Funct3E_i,
  input  logic [DATA_WIDTH-1:0]    ALUResultE_i,
  input  logic [DATA_WIDTH-1:0]    WriteDataE_i,
  input  logic [4:0]               RdE_i,
  input  logic                     RegWriteE_i,
  input  logic [1:0]               ResultSrcE_i,
  output logic                     StallM_o,
  output logic                     ValidW_o,
  output logic                     RegWriteW_o,
  output logic [4:0]               RdW_o,
  output logic [1:0]               ResultSrcW_o,
  output logic [DATA_WIDTH-1:0]    ALUResultW_o,
  output logic [DATA_WIDTH-1:0]    ReadDataW_o,
  output logic                     MisalignW_o,
  output logic                     BusErrW_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     mem_ready_i,
  output logic                     dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Wait count at which the current REQ cycle is the last one allowed.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [7:0]              wait_q;
  logic [1:0]              cap_off;
  logic [2:0]              cap_f3;
  logic                    cap_we;
  logic [4:0]              cap_rd;
  logic                    cap_regwrite;
  logic [1:0]              cap_rs;
  logic [DATA_WIDTH-1:0]   cap_alu;

  logic                    mem_op, bad, start, misalign, ready_hit, timeout, stall_raw;
  logic [1:0]              addr_lo;
  logic [3:0]              be_d;
  logic [31:0]             wdata_d;
  logic [7:0]              sel_byte;
  logic [15:0]             sel_half;
  logic [DATA_WIDTH-1:0]   load_data;

  assign mem_op    = ValidE_i & (MemReadE_i | MemWriteE_i);
  assign addr_lo   = ALUResultE_i[1:0];
  assign start     = (state_q == S_IDLE) & mem_op & ~bad;
  assign misalign  = (state_q == S_IDLE) & mem_op & bad;
  assign ready_hit = (state_q == S_REQ) & mem_ready_i;
  assign timeout   = (state_q == S_REQ) & ~mem_ready_i & (wait_q == WAIT_LAST);
  // Stall is forced low while reset is asserted so every output reads 0.
  assign StallM_o    = stall_raw & rst;
  assign dbg_state_o = state_q;

  // Classify the access size / alignment of the op in E.
  always_comb begin
    bad = 1'b0;
    case (Funct3E_i)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = addr_lo[0];
      3'b010:         bad = (addr_lo != 2'b00);
      default:        bad = 1'b1;
    endcase
  end

  // Next state and stall request.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_REQ;
          stall_raw = 1'b1;
        end
      end
      S_REQ: begin
        stall_raw = ~mem_ready_i & ~timeout;
        if (ready_hit | timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (MemWriteE_i) begin
      case (Funct3E_i[1:0])
        2'b00: begin
          wdata_d = {4{WriteDataE_i[7:0]}};
          be_d    = 4'b0001 << addr_lo;
        end
        2'b01: begin
          wdata_d = {2{WriteDataE_i[15:0]}};
          be_d    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = WriteDataE_i[31:0];
          be_d    = 4'b1111;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of returned load data.
  always_comb begin
    sel_byte = mem_rdata_i[{cap_off, 3'b000} +: 8];
    sel_half = cap_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (cap_f3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Memory request registers, op capture and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= 4'h0;
      mem_wdata_o  <= 32'h0;
      wait_q       <= 8'h0;
      cap_off      <= 2'b00;
      cap_f3       <= 3'b000;
      cap_we       <= 1'b0;
      cap_rd       <= 5'd0;
      cap_regwrite <= 1'b0;
      cap_rs       <= 2'b00;
      cap_alu      <= '0;
    end else if (start) begin
      mem_req_o    <= 1'b1;
      mem_we_o     <= MemWriteE_i;
      mem_addr_o   <= {ALUResultE_i[ADDRESS_WIDTH-1:2], 2'b00};
      mem_be_o     <= be_d;
      mem_wdata_o  <= wdata_d;
      wait_q       <= 8'h0;
      cap_off      <= addr_lo;
      cap_f3       <= Funct3E_i;
      cap_we       <= MemWriteE_i;
      cap_rd       <= RdE_i;
      cap_regwrite <= RegWriteE_i;
      cap_rs       <= ResultSrcE_i;
      cap_alu      <= ALUResultE_i;
    end else if (ready_hit | timeout) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= 4'h0;
      mem_wdata_o  <= 32'h0;
    end else if (state_q == S_REQ) begin
      wait_q <= wait_q + 8'd1;
    end
  end

  // Writeback register: pass-through in IDLE, completion/abort entry from REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ValidW_o     <= 1'b0;
      RegWriteW_o  <= 1'b0;
      RdW_o        <= 5'd0;
      ResultSrcW_o <= 2'b00;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      MisalignW_o  <= 1'b0;
      BusErrW_o    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      ValidW_o     <= ValidE_i & ~start;
      RegWriteW_o  <= ValidE_i & RegWriteE_i & ~mem_op;
      RdW_o        <= RdE_i;
      ResultSrcW_o <= ResultSrcE_i;
      ALUResultW_o <= ALUResultE_i;
      ReadDataW_o  <= '0;
      MisalignW_o  <= misalign;
      BusErrW_o    <= 1'b0;
    end else if (ready_hit | timeout) begin
      ValidW_o     <= 1'b1;
      RegWriteW_o  <= ready_hit & cap_regwrite;
      RdW_o        <= cap_rd;
      ResultSrcW_o <= cap_rs;
      ALUResultW_o <= cap_alu;
      ReadDataW_o  <= (ready_hit & ~cap_we) ? load_data : '0;
      MisalignW_o  <= 1'b0;
      BusErrW_o    <= timeout;
    end else begin
      ValidW_o     <= 1'b0;
      RegWriteW_o  <= 1'b0;
      MisalignW_o  <= 1'b0;
      BusErrW_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage, run back to back through one
// driver task, plus hand-written reset sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ValidE_i, MemReadE_i, MemWriteE_i;
  logic [2:0]  Funct3E_i;
  logic [31:0] ALUResultE_i, WriteDataE_i;
  logic [4:0]  RdE_i;
  logic        RegWriteE_i;
  logic [1:0]  ResultSrcE_i;
  logic        StallM_o, ValidW_o, RegWriteW_o;
  logic [4:0]  RdW_o;
  logic [1:0]  ResultSrcW_o;
  logic [31:0] ALUResultW_o, ReadDataW_o;
  logic        MisalignW_o, BusErrW_o;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .ValidE_i(ValidE_i), .MemReadE_i(MemReadE_i), .MemWriteE_i(MemWriteE_i),
    .Funct3E_i(Funct3E_i), .ALUResultE_i(ALUResultE_i), .WriteDataE_i(WriteDataE_i),
    .RdE_i(RdE_i), .RegWriteE_i(RegWriteE_i), .ResultSrcE_i(ResultSrcE_i),
    .StallM_o(StallM_o), .ValidW_o(ValidW_o), .RegWriteW_o(RegWriteW_o),
    .RdW_o(RdW_o), .ResultSrcW_o(ResultSrcW_o), .ALUResultW_o(ALUResultW_o),
    .ReadDataW_o(ReadDataW_o), .MisalignW_o(MisalignW_o), .BusErrW_o(BusErrW_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  // One directed vector: E inputs, memory response, and expected results.
  // delay = REQ cycles without ready before ready is given; -1 = never.
  typedef struct {
    logic va, mr, mw; logic [2:0] f3; logic [31:0] alu, wd; logic [4:0] rd;
    logic rw; logic [1:0] rs; int delay; logic [31:0] rdata;
    logic e_valid, e_rw, e_mis, e_bus; logic [31:0] e_rdata;
    int e_req, e_stall; logic e_we; logic [7:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t prev;
  bit   has_prev;

  function automatic vec_t mk(
    input logic va, mr, mw, input logic [2:0] f3, input logic [31:0] alu, wd,
    input logic [4:0] rd, input logic rw, input logic [1:0] rs, input int delay,
    input logic [31:0] rdata, input logic e_valid, e_rw, e_mis, e_bus,
    input logic [31:0] e_rdata, input int e_req, e_stall, input logic e_we,
    input logic [7:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata);
    vec_t v;
    v.va = va; v.mr = mr; v.mw = mw; v.f3 = f3; v.alu = alu; v.wd = wd; v.rd = rd;
    v.rw = rw; v.rs = rs; v.delay = delay; v.rdata = rdata;
    v.e_valid = e_valid; v.e_rw = e_rw; v.e_mis = e_mis; v.e_bus = e_bus;
    v.e_rdata = e_rdata; v.e_req = e_req; v.e_stall = e_stall; v.e_we = e_we;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=0x%08h req=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_e(input vec_t v);
    ValidE_i     = v.va;
    MemReadE_i   = v.mr;
    MemWriteE_i  = v.mw;
    Funct3E_i    = v.f3;
    ALUResultE_i = v.alu;
    WriteDataE_i = v.wd;
    RdE_i        = v.rd;
    RegWriteE_i  = v.rw;
    ResultSrcE_i = v.rs;
  endtask

  task automatic drive_bubble();
    ValidE_i = 1'b0; MemReadE_i = 1'b0; MemWriteE_i = 1'b0; Funct3E_i = 3'b000;
    ALUResultE_i = 32'h0; WriteDataE_i = 32'h0; RdE_i = 5'd0;
    RegWriteE_i = 1'b0; ResultSrcE_i = 2'b00;
  endtask

  task automatic check_w(input vec_t v);
    chk("w_valid", {31'h0, ValidW_o}, {31'h0, v.e_valid});
    chk("w_regwrite", {31'h0, RegWriteW_o}, {31'h0, v.e_rw});
    if (v.e_valid) begin
      chk("w_rd", {27'h0, RdW_o}, {27'h0, v.rd});
      chk("w_resultsrc", {30'h0, ResultSrcW_o}, {30'h0, v.rs});
      chk("w_aluresult", ALUResultW_o, v.alu);
      chk("w_readdata", ReadDataW_o, v.e_rdata);
      chk("w_misalign", {31'h0, MisalignW_o}, {31'h0, v.e_mis});
      chk("w_buserr", {31'h0, BusErrW_o}, {31'h0, v.e_bus});
    end
  endtask

  task automatic check_req(input vec_t v);
    chk("mem_we", {31'h0, mem_we_o}, {31'h0, v.e_we});
    chk("mem_addr", {24'h0, mem_addr_o}, {24'h0, v.e_addr});
    chk("mem_be", {28'h0, mem_be_o}, {28'h0, v.e_be});
    if (v.e_we) chk("mem_wdata", mem_wdata_o, v.e_wdata);
  endtask

  // Driver: present one op in E, hold it while stalled, act as the memory,
  // and check the previous op's W entry in the cycle this op is presented.
  task automatic run_vec(input vec_t v);
    int   req_n, stall_n, iter;
    logic stall_s;
    @(posedge clk); #1;
    drive_e(v);
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    if (has_prev) check_w(prev);
    req_n = 0; stall_n = 0; iter = 0;
    stall_s = StallM_o;
    if (stall_s) stall_n++;
    while (stall_s && iter < 40) begin
      iter++;
      @(posedge clk); #1;
      if (mem_req_o) begin
        req_n++;
        if (req_n == v.delay + 1) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = v.rdata;
        end else begin
          mem_ready_i = 1'b0;
          mem_rdata_i = 32'hDEAD_BEEF;
        end
      end else begin
        mem_ready_i = 1'b0;
      end
      @(negedge clk);
      if (mem_req_o) check_req(v);
      stall_s = StallM_o;
      if (stall_s) stall_n++;
    end
    if (iter >= 40) chk("stall_bound", 32'(iter), 32'd39);
    chk("req_cycles", 32'(req_n), 32'(v.e_req));
    chk("stall_cycles", 32'(stall_n), 32'(v.e_stall));
    prev = v;
    has_prev = 1'b1;
  endtask

  task automatic flush();
    @(posedge clk); #1;
    drive_bubble();
    mem_ready_i = 1'b0;
    @(negedge clk);
    if (has_prev) check_w(prev);
    has_prev = 1'b0;
  endtask

  initial begin
    //              va mr mw f3      alu           wd            rd  rw rs dly rdata
    //              ev erw mis bus e_rdata         req stl we addr   be     wdata
    vecs.push_back(mk(1, 0, 0, 3'b000, 32'h12, 32'h0, 5'd5, 1, 2'd0, 0, 32'h0,
                      1, 1, 0, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // add
    vecs.push_back(mk(1, 1, 0, 3'b000, 32'h03, 32'h0, 5'd7, 1, 2'd1, 0, 32'h80FF_FF00,
                      1, 1, 0, 0, 32'hFFFF_FF80, 1, 1, 0, 8'h00, 4'hF, 32'h0));    // lb
    vecs.push_back(mk(1, 1, 0, 3'b100, 32'h03, 32'h0, 5'd8, 1, 2'd1, 0, 32'h80FF_FF00,
                      1, 1, 0, 0, 32'h0000_0080, 1, 1, 0, 8'h00, 4'hF, 32'h0));    // lbu
    vecs.push_back(mk(1, 0, 1, 3'b001, 32'h06, 32'h1234_ABCD, 5'd0, 0, 2'd0, 3, 32'h0,
                      1, 0, 0, 0, 32'h0, 4, 4, 1, 8'h04, 4'hC, 32'hABCD_ABCD));    // sh wait 3
    vecs.push_back(mk(1, 1, 0, 3'b010, 32'h05, 32'h0, 5'd9, 1, 2'd1, 0, 32'h0,
                      1, 0, 1, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // lw misaligned
    vecs.push_back(mk(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd10, 1, 2'd1, -1, 32'h0,
                      1, 0, 0, 1, 32'h0, 15, 15, 0, 8'h40, 4'hF, 32'h0));          // lw timeout
    vecs.push_back(mk(1, 0, 1, 3'b000, 32'h12, 32'h0000_00A5, 5'd0, 0, 2'd0, 0, 32'h0,
                      1, 0, 0, 0, 32'h0, 1, 1, 1, 8'h10, 4'h4, 32'hA5A5_A5A5));    // sb
    vecs.push_back(mk(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd11, 1, 2'd1, 0, 32'h8001_7FFF,
                      1, 1, 0, 0, 32'hFFFF_8001, 1, 1, 0, 8'h20, 4'hF, 32'h0));    // lh upper
    vecs.push_back(mk(1, 1, 0, 3'b101, 32'h20, 32'h0, 5'd12, 1, 2'd1, 0, 32'h8001_F00F,
                      1, 1, 0, 0, 32'h0000_F00F, 1, 1, 0, 8'h20, 4'hF, 32'h0));    // lhu lower
    vecs.push_back(mk(1, 1, 0, 3'b010, 32'h44, 32'h0, 5'd13, 1, 2'd1, 1, 32'hCAFE_BABE,
                      1, 1, 0, 0, 32'hCAFE_BABE, 2, 2, 0, 8'h44, 4'hF, 32'h0));    // lw wait 1
    vecs.push_back(mk(1, 0, 1, 3'b010, 32'h1FC, 32'h1122_3344, 5'd0, 0, 2'd0, 0, 32'h0,
                      1, 0, 0, 0, 32'h0, 1, 1, 1, 8'hFC, 4'hF, 32'h1122_3344));    // sw top addr
    vecs.push_back(mk(1, 1, 0, 3'b011, 32'h08, 32'h0, 5'd14, 1, 2'd1, 0, 32'h0,
                      1, 0, 1, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // bad funct3
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h30, 32'h0, 5'd15, 1, 2'd1, 0, 32'h0,
                      0, 0, 0, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // bubble
    vecs.push_back(mk(1, 1, 0, 3'b001, 32'h01, 32'h0, 5'd16, 1, 2'd1, 0, 32'h0,
                      1, 0, 1, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // lh misaligned
    vecs.push_back(mk(1, 1, 1, 3'b000, 32'h01, 32'h0000_005A, 5'd0, 0, 2'd0, 0, 32'h0,
                      1, 0, 0, 0, 32'h0, 1, 1, 1, 8'h00, 4'h2, 32'h5A5A_5A5A));    // rd+wr = sb
    vecs.push_back(mk(1, 1, 0, 3'b000, 32'h01, 32'h0, 5'd17, 1, 2'd1, 0, 32'h0000_7F00,
                      1, 1, 0, 0, 32'h0000_007F, 1, 1, 0, 8'h00, 4'hF, 32'h0));    // lb positive
    vecs.push_back(mk(1, 0, 1, 3'b010, 32'h02, 32'hFFFF_FFFF, 5'd0, 0, 2'd0, 0, 32'h0,
                      1, 0, 1, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // sw misaligned
    vecs.push_back(mk(1, 0, 0, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd31, 0, 2'd2, 0, 32'h0,
                      1, 0, 0, 0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0));            // alu, no rd write

    // Reset: every output reads 0.
    rst = 1'b0;
    drive_bubble();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    has_prev = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, ValidW_o}, 32'h0);
    chk("rst_regwrite", {31'h0, RegWriteW_o}, 32'h0);
    chk("rst_stall", {31'h0, StallM_o}, 32'h0);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_flags", {30'h0, MisalignW_o, BusErrW_o}, 32'h0);
    chk("rst_data", ALUResultW_o | ReadDataW_o | mem_wdata_o, 32'h0);
    chk("rst_state", {31'h0, dbg_state_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Table run, ops presented back to back.
    foreach (vecs[i]) run_vec(vecs[i]);
    flush();

    // Reset asserted two cycles into a waiting REQ.
    @(posedge clk); #1;
    drive_e(vecs[5]);
    mem_ready_i = 1'b0;
    @(negedge clk);
    chk("rstreq_stall0", {31'h0, StallM_o}, 32'h1);
    @(posedge clk); #1;
    chk("rstreq_req1", {31'h0, mem_req_o}, 32'h1);
    @(posedge clk); #1;
    chk("rstreq_req2", {31'h0, mem_req_o}, 32'h1);
    #2;
    rst = 1'b0;
    drive_bubble();
    #1;
    chk("rstreq_req_drop", {31'h0, mem_req_o}, 32'h0);
    chk("rstreq_stall_drop", {31'h0, StallM_o}, 32'h0);
    chk("rstreq_state", {31'h0, dbg_state_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstreq_no_w", {31'h0, ValidW_o}, 32'h0);
      chk("rstreq_no_req", {31'h0, mem_req_o}, 32'h0);
    end

    // Next ops after reset behave normally.
    has_prev = 1'b0;
    run_vec(vecs[9]);
    run_vec(vecs[3]);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined RV32I core, between execute and writeback. It takes the execute-stage result and, for loads and stores, runs a request/ready transaction to data memory with byte enables. Load data is aligned and sign/zero-extended before it is registered toward writeback. While a transaction is outstanding it raises a stall to the hazard unit, and it turns misaligned accesses and memory timeouts into flagged, non-writing writeback entries.

## Interface
- DATA_WIDTH, 32, datapath width; fixed at 32 because byte lanes are 4.
- ADDRESS_WIDTH, 8, data-memory byte-address width.
- TIMEOUT, 15, maximum REQ cycles without ready before abort; range 1–255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ValidE_i  in  1  execute slot holds a real instruction.
- MemReadE_i / MemWriteE_i  in  1 each  load / store.
- Funct3E_i  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ALUResultE_i  in  DATA_WIDTH  effective address, or ALU result for non-memory ops.
- WriteDataE_i  in  DATA_WIDTH  store data from rs2.
- RdE_i  in  5; RegWriteE_i  in  1; ResultSrcE_i  in  2  writeback control, passed through.
- StallM_o  out  1  hold fetch, decode and execute.
- ValidW_o, RegWriteW_o, RdW_o[4:0], ResultSrcW_o[1:0], ALUResultW_o, ReadDataW_o  out  writeback register.
- MisalignW_o  out  1  misaligned or unsupported-size access.
- BusErrW_o  out  1  memory timeout.
- mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDRESS_WIDTH  word address (bits [1:0] = 0); mem_be_o  out  4; mem_wdata_o  out  32.
- mem_rdata_i  in  32; mem_ready_i  in  1.

## Operation
- A memory op is ValidE_i & (MemReadE_i | MemWriteE_i).
- If MemWriteE_i and MemReadE_i are both high, the op is a store.
- States are IDLE and REQ.
- IDLE, non-memory op or bubble:
  - Pass-through to the W register at the next edge.
  - ValidW_o = ValidE_i.
  - RegWriteW_o = RegWriteE_i & ValidE_i.
- IDLE, memory op, bad alignment or size:
  - Bad means: h/hu with addr[0] = 1; w with addr[1:0] ≠ 0; funct3 011, 110 or 111.
  - No request and no stall.
  - Next edge: ValidW_o = 1, MisalignW_o = 1, RegWriteW_o = 0.
- IDLE, aligned memory op:
  - StallM_o is driven high combinationally.
  - At the edge: capture address, size, data, Rd and control; go to REQ; load mem_req_o = 1.
- REQ:
  - mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are held constant.
  - StallM_o = ~mem_ready_i & ~timeout.
  - E inputs are ignored.
- REQ, mem_ready_i = 1:
  - Load: ReadDataW_o = extracted mem_rdata_i.
  - ValidW_o = 1; RegWriteW_o = captured RegWrite.
  - mem_req_o = 0; return to IDLE.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ cycle without ready.
  - When count = TIMEOUT: abort with mem_req_o = 0, ValidW_o = 1, BusErrW_o = 1, RegWriteW_o = 0; return to IDLE.
- Store lanes:
  - sb: wdata = 4 copies of byte [7:0]; be = 1 << addr[1:0].
  - sh: wdata = 2 copies of half [15:0]; be = 0011 if addr[1] = 0, else 1100.
  - sw: be = 1111.
  - mem_we_o = 1.
- Load lanes:
  - be = 1111, mem_we_o = 0.
  - b/bu select byte addr[1:0]; h/hu select half addr[1].
  - b/h sign-extend; bu/hu zero-extend.
- ALUResultW_o always carries the address or ALU result.
- MisalignW_o, BusErrW_o and ReadDataW_o are 0 for entries they do not apply to.

## Timing
- Reset:
  - All outputs are 0 and state is IDLE.
  - Assertion mid-REQ drops mem_req_o immediately and discards the op; no W entry is produced.
- Non-memory op: 1-cycle latency, no stall.
- Memory op with ready on the first REQ cycle:
  - E presented in cycle 0.
  - Cycle 1 is REQ with ready.
  - W valid in cycle 2.
  - StallM_o is high in cycle 0 only.
- Each wait cycle adds one cycle of latency and one stall cycle.
- Upstream holds E stable while StallM_o = 1.
- On the completion cycle StallM_o = 0, so the next instruction reaches E one cycle later and is never re-captured.
- mem_rdata_i is sampled only in the cycle where mem_req_o & mem_ready_i.
- mem_ready_i is ignored in IDLE.
- Back-to-back memory ops: IDLE accepts the next op in the cycle after completion; there is no dead cycle beyond that.

## Test plan
- add result 0x12, Rd 5 → next cycle ValidW_o = 1, ALUResultW_o = 0x12, RdW_o = 5, StallM_o never high.
- lb addr 0x03, rdata 0x80FF_FF00, ready on first REQ → W in cycle 2 with ReadDataW_o = 0xFFFF_FF80; lbu same → 0x0000_0080.
- sh addr 0x06, data 0x1234_ABCD, ready delayed 3 cycles → mem_addr_o = 0x04, be = 1100, wdata = 0xABCD_ABCD, StallM_o high for 4 cycles, W valid with RegWriteW_o = 0.
- lw addr 0x05 → no mem_req_o, next cycle MisalignW_o = 1, RegWriteW_o = 0.
- lw with ready never asserted, TIMEOUT = 15 → abort after 15 REQ cycles, BusErrW_o = 1, StallM_o falls in the abort cycle.
- rst low two cycles into a waiting REQ → mem_req_o = 0 immediately, no W valid after release, next op handled normally.
